// File: rtl/bank_rr_arbiter_if.sv
// Requester/bank bundle for bank_rr_arbiter; the lock vector exists only when ARB_LOCK_EN is defined.
// slave is the arbiter's view, master is the requester/bank-model view.
interface bank_rr_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
   logic [NUM_REQ-1:0]            wr;
   logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
   logic [NUM_REQ-1:0]            gnt;
   logic [NUM_REQ-1:0]            rvalid;
   logic [DATA_WIDTH-1:0]         rdata;
   logic                          mem_en;
   logic                          mem_we;
   logic [ADDR_WIDTH-1:0]         mem_addr;
   logic [DATA_WIDTH-1:0]         mem_wdata;
   logic [DATA_WIDTH-1:0]         mem_rdata;
`ifdef ARB_LOCK_EN
   logic [NUM_REQ-1:0]            lock;

   modport slave (
      input  req, addr, wr, wdata, lock, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, addr, wr, wdata, lock, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
`else
   modport slave (
      input  req, addr, wr, wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, addr, wr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
`endif
endinterface

// File: rtl/bank_rr_arbiter.sv
// Round-robin arbiter sharing one fixed-latency SRAM bank among NUM_REQ requesters.
// Define ARB_LOCK_EN to add per-requester lock (OPEN/LOCKED owner hold with frozen pointer).
module bank_rr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 2
) (
   input logic              clk,
   input logic              rst,
   bank_rr_arbiter_if.slave bus
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_REQ - 1);
   localparam logic [IDW-1:0] ONE_ID  = IDW'(1);

   logic [IDW-1:0]        ptr;
   logic [IDW-1:0]        ptr_nxt;
   logic [NUM_REQ-1:0]    eligible;
   logic [NUM_REQ-1:0]    gnt_c;
   logic                  grant_any;
   logic [IDW-1:0]        grant_id;
   logic                  hold;
   int                    idx;

   logic                  mem_en_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [DATA_WIDTH-1:0] mem_wdata_q;
   logic [NUM_REQ-1:0]    rvalid_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [RD_LATENCY:0]   pipe_vld;
   logic [IDW-1:0]        pipe_id [RD_LATENCY+1];

`ifdef ARB_LOCK_EN
   typedef enum logic {OPEN, LOCKED} lock_state_t;
   lock_state_t    state, state_nxt;
   logic [IDW-1:0] owner, owner_nxt;

   // Lock FSM state register; owner is only meaningful while LOCKED.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= OPEN;
         owner <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end
`endif

   // Arbitration: a held lock narrows eligibility to the owner, otherwise scan upward from ptr with wrap.
   always_comb begin
      eligible  = bus.req;
      hold      = 1'b0;
      grant_any = 1'b0;
      grant_id  = '0;
      gnt_c     = '0;
      ptr_nxt   = ptr;
      idx       = 0;
`ifdef ARB_LOCK_EN
      state_nxt = state;
      owner_nxt = owner;
      if (state == LOCKED) begin
         if (bus.req[owner] && bus.lock[owner]) begin
            hold            = 1'b1;
            eligible        = '0;
            eligible[owner] = 1'b1;
         end else begin
            state_nxt = OPEN;
         end
      end
`endif
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!grant_any && eligible[idx]) begin
            grant_any = 1'b1;
            grant_id  = IDW'(idx);
         end
      end
      if (rst) grant_any = 1'b0;
      if (grant_any) begin
         gnt_c[grant_id] = 1'b1;
         if (!hold) ptr_nxt = (grant_id == LAST_ID) ? '0 : grant_id + ONE_ID;
`ifdef ARB_LOCK_EN
         if (!hold && bus.lock[grant_id]) begin
            state_nxt = LOCKED;
            owner_nxt = grant_id;
         end
`endif
      end
   end

   // Register the granted command toward the bank; address/data hold when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr         <= '0;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         ptr      <= ptr_nxt;
         mem_en_q <= grant_any;
         if (grant_any) begin
            mem_we_q    <= bus.wr[grant_id];
            mem_addr_q  <= bus.addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_q <= bus.wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Read tags travel alongside the bank latency so the last stage lines up with valid mem_rdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe_vld <= '0;
         for (int k = 0; k <= RD_LATENCY; k++) pipe_id[k] <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         pipe_vld[0] <= grant_any && !bus.wr[grant_id];
         pipe_id[0]  <= grant_id;
         for (int k = 1; k <= RD_LATENCY; k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
            pipe_id[k]  <= pipe_id[k-1];
         end
         rvalid_q <= '0;
         if (pipe_vld[RD_LATENCY]) begin
            rvalid_q[pipe_id[RD_LATENCY]] <= 1'b1;
            rdata_q                       <= bus.mem_rdata;
         end
      end
   end

   assign bus.gnt       = gnt_c;
   assign bus.rvalid    = rvalid_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_bank_rr_arbiter.sv
// Self-checking bench for bank_rr_arbiter: bank model plus a read-return scoreboard.
// Lock scenario is compiled in only when ARB_LOCK_EN is defined.
`timescale 1ns/1ps
module tb_bank_rr_arbiter;
   localparam int NUM_REQ    = 4;
   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 32;
   localparam int RD_LATENCY = 2;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] data;
      logic [31:0] due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sb [$];
   exp_t got_e;

   logic [DATA_WIDTH-1:0] bank    [256];
   logic [DATA_WIDTH-1:0] ref_mem [256];
   logic [DATA_WIDTH-1:0] rd_pipe [RD_LATENCY];

   bank_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

   bank_rr_arbiter #(
      .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .RD_LATENCY(RD_LATENCY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Fixed-latency bank: a read command seen in cycle C presents data in cycle C+RD_LATENCY.
   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) bank[bus.mem_addr[7:0]] <= bus.mem_wdata;
      rd_pipe[0] <= (bus.mem_en && !bus.mem_we) ? bank[bus.mem_addr[7:0]] : '0;
      for (int k = 1; k < RD_LATENCY; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign bus.mem_rdata = rd_pipe[RD_LATENCY-1];

   // Read-return monitor: every rvalid must match the oldest expected read, on its due cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.rvalid !== '0) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("[TB] FAIL rvalid_unexpected got=%b need=0000", bus.rvalid);
            end else begin
               got_e = sb.pop_front();
               if (bus.rvalid !== (4'b0001 << got_e.id) || bus.rdata !== got_e.data || cyc != int'(got_e.due)) begin
                  bad++;
                  $display("[TB] FAIL read_return got rvalid=%b rdata=%h cyc=%0d need rvalid=%b rdata=%h cyc=%0d",
                           bus.rvalid, bus.rdata, cyc, 4'b0001 << got_e.id, got_e.data, got_e.due);
               end
            end
         end else if (sb.size() != 0 && cyc > int'(sb[0].due)) begin
            total++;
            bad++;
            got_e = sb.pop_front();
            $display("[TB] FAIL read_missing got rvalid=0000 need id=%0d at cyc=%0d", got_e.id, got_e.due);
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout got=running need=finished");
      $fatal(1, "[TB] timeout");
   end

   task automatic set_port(input int i, input logic w, input logic [15:0] a, input logic [31:0] d);
      bus.wr[i]                        = w;
      bus.addr[i*ADDR_WIDTH +: ADDR_WIDTH] = a;
      bus.wdata[i*DATA_WIDTH +: DATA_WIDTH] = d;
   endtask

   // Record what the bench expects from a grant to requester i: write updates the reference, read is queued.
   task automatic book_grant(input int i);
      logic [7:0] a;
      exp_t       e;
      a = bus.addr[i*ADDR_WIDTH +: 8];
      if (bus.wr[i]) begin
         ref_mem[a] = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         e.id   = 2'(i);
         e.data = ref_mem[a];
         e.due  = 32'(cyc + RD_LATENCY + 2);
         sb.push_back(e);
      end
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 12 && sb.size() != 0; k++) @(negedge clk);
      @(negedge clk);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain_%s got pending=%0d need pending=0", tag, sb.size());
         sb.delete();
      end
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      bus.req = '1;
      @(negedge clk);
      @(negedge clk);
      total += 7;
      if (bus.gnt !== 4'b0000) begin bad++; $display("[TB] FAIL reset_gnt got=%b need=0000", bus.gnt); end
      if (bus.rvalid !== 4'b0000) begin bad++; $display("[TB] FAIL reset_rvalid got=%b need=0000", bus.rvalid); end
      if (bus.rdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_rdata got=%h need=0", bus.rdata); end
      if (bus.mem_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_en got=%b need=0", bus.mem_en); end
      if (bus.mem_we !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_we got=%b need=0", bus.mem_we); end
      if (bus.mem_addr !== 16'h0) begin bad++; $display("[TB] FAIL reset_mem_addr got=%h need=0", bus.mem_addr); end
      if (bus.mem_wdata !== 32'h0) begin bad++; $display("[TB] FAIL reset_mem_wdata got=%h need=0", bus.mem_wdata); end
      @(posedge clk); #1;
      rst     = 1'b0;
      bus.req = '0;
   endtask

   task automatic test_all_reads();
      logic [3:0] exp_g;
      for (int i = 0; i < NUM_REQ; i++) set_port(i, 1'b0, 16'h0020 + 16'(i), 32'h0);
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         bus.req = 4'b1111;
         @(negedge clk);
         exp_g = 4'b0001 << (k % 4);
         total++;
         if (bus.gnt !== exp_g) begin bad++; $display("[TB] FAIL all_reads_gnt k=%0d got=%b need=%b", k, bus.gnt, exp_g); end
         if (k > 0) begin
            total++;
            if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0020 + 16'((k - 1) % 4)) begin
               bad++;
               $display("[TB] FAIL all_reads_cmd k=%0d got en=%b we=%b addr=%h need en=1 we=0 addr=%h",
                        k, bus.mem_en, bus.mem_we, bus.mem_addr, 16'h0020 + 16'((k - 1) % 4));
            end
         end
         book_grant(k % 4);
      end
      @(posedge clk); #1;
      bus.req = '0;
      drain("all_reads");
   endtask

   task automatic test_write_read();
      @(posedge clk); #1;
      set_port(2, 1'b1, 16'h0010, 32'hDEADBEEF);
      bus.req = 4'b0100;
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0100) begin bad++; $display("[TB] FAIL wr_gnt got=%b need=0100", bus.gnt); end
      book_grant(2);
      @(posedge clk); #1;
      set_port(0, 1'b0, 16'h0010, 32'h0);
      bus.req = 4'b0001;
      @(negedge clk);
      total += 2;
      if (bus.gnt !== 4'b0001) begin bad++; $display("[TB] FAIL rd_gnt got=%b need=0001", bus.gnt); end
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 32'hDEADBEEF) begin
         bad++;
         $display("[TB] FAIL wr_cmd got en=%b we=%b addr=%h wdata=%h need en=1 we=1 addr=0010 wdata=deadbeef",
                  bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      book_grant(0);
      @(posedge clk); #1;
      bus.req = '0;
      @(negedge clk);
      total++;
      if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0010) begin
         bad++;
         $display("[TB] FAIL rd_cmd got en=%b we=%b addr=%h need en=1 we=0 addr=0010", bus.mem_en, bus.mem_we, bus.mem_addr);
      end
      drain("write_read");
   endtask

   task automatic test_single_persistent();
      set_port(3, 1'b0, 16'h0030, 32'h0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         bus.req = 4'b1000;
         @(negedge clk);
         total++;
         if (bus.gnt !== 4'b1000) begin bad++; $display("[TB] FAIL single_gnt k=%0d got=%b need=1000", k, bus.gnt); end
         if (k > 0) begin
            total++;
            if (bus.mem_en !== 1'b1) begin bad++; $display("[TB] FAIL single_mem_en k=%0d got=%b need=1", k, bus.mem_en); end
         end
         book_grant(3);
      end
      @(posedge clk); #1;
      bus.req = '0;
      drain("single");
   endtask

   task automatic test_ptr_order();
      @(posedge clk); #1;
      set_port(1, 1'b1, 16'h0040, 32'h11111111);
      bus.req = 4'b0010;
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0010) begin bad++; $display("[TB] FAIL ptr_setup_gnt got=%b need=0010", bus.gnt); end
      book_grant(1);
      @(posedge clk); #1;
      set_port(0, 1'b1, 16'h0041, 32'h22222222);
      set_port(1, 1'b1, 16'h0042, 32'h33333333);
      bus.req = 4'b0011;
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0001) begin bad++; $display("[TB] FAIL ptr_wrap_gnt got=%b need=0001", bus.gnt); end
      book_grant(0);
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0010) begin bad++; $display("[TB] FAIL ptr_next_gnt got=%b need=0010", bus.gnt); end
      book_grant(1);
      @(posedge clk); #1;
      bus.req = '0;
      drain("ptr_order");
   endtask

   task automatic test_reset_mid_flight();
      set_port(0, 1'b0, 16'h0010, 32'h0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         bus.req = 4'b0001;
         @(negedge clk);
         total++;
         if (bus.gnt !== 4'b0001) begin bad++; $display("[TB] FAIL mid_gnt k=%0d got=%b need=0001", k, bus.gnt); end
      end
      @(posedge clk); #1;
      rst     = 1'b1;
      bus.req = 4'b0001;
      @(negedge clk);
      total += 4;
      if (bus.gnt !== 4'b0000) begin bad++; $display("[TB] FAIL mid_rst_gnt got=%b need=0000", bus.gnt); end
      if (bus.mem_en !== 1'b0) begin bad++; $display("[TB] FAIL mid_rst_mem_en got=%b need=0", bus.mem_en); end
      if (bus.rdata !== 32'h0 || bus.rvalid !== 4'b0000) begin
         bad++;
         $display("[TB] FAIL mid_rst_ret got rdata=%h rvalid=%b need rdata=0 rvalid=0000", bus.rdata, bus.rvalid);
      end
      if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 32'h0) begin
         bad++;
         $display("[TB] FAIL mid_rst_cmd got we=%b addr=%h wdata=%h need 0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
      end
      @(posedge clk); #1;
      rst     = 1'b0;
      bus.req = '0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         total++;
         if (bus.rvalid !== 4'b0000) begin bad++; $display("[TB] FAIL mid_after_rvalid k=%0d got=%b need=0000", k, bus.rvalid); end
      end
   endtask

   // Random mixed traffic against a reference round-robin model; starts right after a reset (ptr=0).
   task automatic test_back_to_back();
      int         mptr;
      int         g;
      int         idx;
      logic [3:0] r;
      logic [3:0] exp_g;
      logic       pen;
      logic       pwe;
      logic [15:0] pa;
      logic [31:0] pd;
      mptr = 0;
      pen  = 1'b0;
      pwe  = 1'b0;
      pa   = '0;
      pd   = '0;
      for (int k = 0; k < 32; k++) begin
         @(posedge clk); #1;
         r       = 4'($urandom_range(0, 15));
         bus.req = r;
         for (int i = 0; i < NUM_REQ; i++)
            set_port(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 31)), $urandom);
         @(negedge clk);
         g = -1;
         for (int j = 0; j < NUM_REQ; j++) begin
            idx = (mptr + j) % NUM_REQ;
            if (g < 0 && r[idx]) g = idx;
         end
         exp_g = (g < 0) ? 4'b0000 : (4'b0001 << g);
         total += 2;
         if (bus.gnt !== exp_g) begin bad++; $display("[TB] FAIL b2b_gnt k=%0d got=%b need=%b", k, bus.gnt, exp_g); end
         if (bus.mem_en !== pen || (pen && (bus.mem_we !== pwe || bus.mem_addr !== pa || bus.mem_wdata !== pd))) begin
            bad++;
            $display("[TB] FAIL b2b_cmd k=%0d got en=%b we=%b addr=%h wdata=%h need en=%b we=%b addr=%h wdata=%h",
                     k, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, pen, pwe, pa, pd);
         end
         if (g >= 0) begin
            book_grant(g);
            pen  = 1'b1;
            pwe  = bus.wr[g];
            pa   = bus.addr[g*ADDR_WIDTH +: ADDR_WIDTH];
            pd   = bus.wdata[g*DATA_WIDTH +: DATA_WIDTH];
            mptr = (g + 1) % NUM_REQ;
         end else begin
            pen = 1'b0;
         end
      end
      @(posedge clk); #1;
      bus.req = '0;
      drain("b2b");
   endtask

`ifdef ARB_LOCK_EN
   task automatic test_lock();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) set_port(i, 1'b1, 16'h0050 + 16'(i), 32'(i));
      @(posedge clk); #1;
      bus.req  = 4'b0010;
      bus.lock = 4'b0010;
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0010) begin bad++; $display("[TB] FAIL lock_take_gnt got=%b need=0010", bus.gnt); end
      book_grant(1);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         bus.req = 4'b1111;
         @(negedge clk);
         total++;
         if (bus.gnt !== 4'b0010) begin bad++; $display("[TB] FAIL lock_hold_gnt k=%0d got=%b need=0010", k, bus.gnt); end
         book_grant(1);
      end
      @(posedge clk); #1;
      bus.lock = 4'b0000;
      @(negedge clk);
      total++;
      if (bus.gnt !== 4'b0100) begin bad++; $display("[TB] FAIL lock_release_gnt got=%b need=0100", bus.gnt); end
      book_grant(2);
      @(posedge clk); #1;
      bus.req = '0;
      drain("lock");
   endtask
`endif

   initial begin
      for (int i = 0; i < 256; i++) begin
         bank[i]    = 32'hA5000000 + 32'(i);
         ref_mem[i] = 32'hA5000000 + 32'(i);
      end
      bus.req   = '0;
      bus.wr    = '0;
      bus.addr  = '0;
      bus.wdata = '0;
`ifdef ARB_LOCK_EN
      bus.lock  = '0;
`endif
      $display("[TB] starting bank_rr_arbiter bench");
      test_reset();
      test_all_reads();
      test_write_read();
      test_single_persistent();
      test_ptr_order();
      test_reset_mid_flight();
      test_back_to_back();
`ifdef ARB_LOCK_EN
      test_lock();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/bank_rr_arbiter.md
Name: bank_rr_arbiter

Overview:
- Shares one single-port SRAM bank among NUM_REQ requesters with round-robin fairness; at most one access is issued per cycle.
- Sits between the requester ports and a fixed-latency bank macro.
- Tracks in-flight reads in a latency-matched pipeline so read data is routed back to the originating requester.
- Writes are posted; they produce no response.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
ADDR_WIDTH, 16, bank address width
DATA_WIDTH, 32, data width
RD_LATENCY, 2, cycles from mem_en read command to mem_rdata valid (1..4)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  NUM_REQ  per-requester access request
addr  in  NUM_REQ*ADDR_WIDTH  per-requester address, packed, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
wr  in  NUM_REQ  1=write, 0=read
wdata  in  NUM_REQ*DATA_WIDTH  per-requester write data, packed
gnt  out  NUM_REQ  one-hot grant, combinational
rvalid  out  NUM_REQ  one-hot read-return strobe, registered
rdata  out  DATA_WIDTH  shared read-return data, registered
mem_en  out  1  bank access enable, registered
mem_we  out  1  bank write enable, registered
mem_addr  out  ADDR_WIDTH  bank address, registered
mem_wdata  out  DATA_WIDTH  bank write data, registered
mem_rdata  in  DATA_WIDTH  bank read data

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0; round-robin pointer ptr=0; read-tracking pipeline cleared.
- Handshake: a requester holds req, addr, wr and wdata stable until it sees gnt. The transfer completes in the gnt cycle. The requester may change inputs or drop req in the cycle after gnt.
- Arbitration (cycle T, combinational):
  - Search req starting at index ptr, ascending, wrapping NUM_REQ-1 -> 0.
  - The first set bit i gets gnt[i]=1; at most one gnt bit is set.
  - No req: gnt=0.
- Pointer update at end of T:
  - If a grant was issued to i: ptr <= (i==NUM_REQ-1) ? 0 : i+1.
  - Otherwise ptr holds.
- Issue: at the T edge, the granted requester's command is registered. During T+1: mem_en=1, mem_we=wr[i], mem_addr=addr[i], mem_wdata=wdata[i]. With no grant in T, mem_en=0 in T+1 and the other mem_* outputs hold their previous values.
- Read tracking:
  - Shift pipeline of depth RD_LATENCY+1 carries {valid, requester id ($clog2(NUM_REQ) bits)}.
  - An entry is inserted at the T edge for reads only.
  - mem_rdata is sampled at cycle T+1+RD_LATENCY.
  - rdata/rvalid[id] are registered and visible in cycle T+2+RD_LATENCY (T+4 at default).
  - rvalid is one-hot and single-cycle. rdata holds its last value when rvalid=0.
- Throughput: back-to-back grants every cycle; reads and writes may interleave freely with no bubbles. Write-after-read ordering to the bank is issue order.
- Boundaries:
  - All req high: grants 0,1,2,3,0,... one per cycle.
  - A single persistent requester is granted every cycle.
  - ptr wrap from NUM_REQ-1 to 0 is seamless.
  - A requester that drops req before gnt is simply skipped; no state is kept.
- Reset mid-operation: all in-flight reads are discarded; no rvalid is produced for them after reset release; mem_en=0 immediately (asynchronous).

Optional Feature:
- Macro: ARB_LOCK_EN
- Defined:
  - Adds input lock, NUM_REQ bits. Two-state FSM: OPEN / LOCKED(owner).
  - In OPEN: a grant to i with lock[i]=1 moves to LOCKED, owner=i.
  - In LOCKED: only owner is eligible; others see gnt=0 regardless of ptr; ptr is frozen.
  - Returns to OPEN on the first cycle owner's req or lock is low. That cycle arbitrates normally from the frozen ptr.
  - Reset -> OPEN.
- Undefined: no lock port; pure round-robin.

Test Plan:
- Reset, then req=4'b1111 all reads, held for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; rvalid follows the same order 4 cycles after each gnt; rdata matches the bank model.
- Requester 2 writes 0xDEADBEEF to 0x0010; next cycle requester 0 reads 0x0010 -> mem_we=1 then mem_we=0 on consecutive cycles; rvalid[0] with rdata=0xDEADBEEF.
- Only req[3] high for 5 cycles -> gnt[3] every cycle; ptr wraps to 0 each time; mem_en continuously 1.
- ptr=2, req=4'b0011 -> gnt=0001 first, then gnt=0010.
- Reads issued on 3 consecutive cycles, rst pulsed for 1 cycle mid-flight -> no rvalid after release; all outputs at reset values during rst.
- With ARB_LOCK_EN: requester 1 granted with lock[1]=1 while req=4'b1111 -> only gnt[1] while lock held; after lock[1] drops, next grant goes to 2.
